// File: rtl/amax10_qsys_pio_pkg.sv
// Shared register offsets and edge-select encodings for the Qsys-style PIO blocks.
package amax10_qsys_pio_pkg;

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5
  } reg_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Per-bit edge flags from the current and previous synchronised samples.
  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int          edge_type);
    case (edge_type)
      EDGE_FALLING: return ~cur & prev;
      EDGE_ANY:     return cur ^ prev;
      default:      return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/amax10_qsys_pio_sync.sv
// Multi-stage flip-flop synchroniser for the PIO pin inputs, async reset to zero.
module amax10_qsys_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/amax10_qsys_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, set/clear output access,
// synchronised pin reads, edge capture with W1C and a masked level interrupt.
module amax10_qsys_bidir_pio
  import amax10_qsys_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [WIDTH-1:0] out_q, dir_q, mask_q, ec_q, ec_next;
  logic [WIDTH-1:0] sync_q, dly_q, det, w1c, wd;
  logic [31:0]      det_full, rd_next;
  logic [2:0]       arm_cnt;
  logic             capture_en, wr_en, unused_ok;

  // Handshake: a write is accepted on any rising edge with chipselect=1 and
  // write_n=0; there are no wait states and reads are always one cycle late.
  assign wr_en = chipselect && !write_n;
  assign wd    = writedata[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  amax10_qsys_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (sync_q)
  );

  assign det_full   = edge_detect(32'(sync_q), 32'(dly_q), EDGE_TYPE);
  assign det        = det_full[WIDTH-1:0];
  assign capture_en = (arm_cnt == 3'(ARM_CYCLES));
  assign w1c        = (wr_en && address == REG_EDGECAP) ? wd : '0;
  // Set beats clear: a fresh edge in the clearing cycle keeps its bit.
  assign ec_next    = (ec_q & ~w1c) | (capture_en ? det : '0);
  assign irq        = |(ec_q & mask_q);
  assign unused_ok  = ^{writedata, det_full};

  always_comb begin
    rd_next = '0;
    case (address)
      REG_DATA:    rd_next[WIDTH-1:0] = sync_q;
      REG_DIR:     rd_next[WIDTH-1:0] = dir_q;
      REG_IRQMASK: rd_next[WIDTH-1:0] = mask_q;
      REG_EDGECAP: rd_next[WIDTH-1:0] = ec_q;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_OUT;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
    end else if (wr_en) begin
      case (address)
        REG_DATA:    out_q  <= wd;
        REG_DIR:     dir_q  <= wd;
        REG_IRQMASK: mask_q <= wd;
        REG_OUTSET:  out_q  <= out_q | wd;
        REG_OUTCLR:  out_q  <= out_q & ~wd;
        default:     ;
      endcase
    end
  end

  // Capture stays disarmed until the synchroniser and delay stage hold real pin data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ec_q     <= '0;
      dly_q    <= '0;
      readdata <= '0;
      arm_cnt  <= '0;
    end else begin
      ec_q     <= ec_next;
      dly_q    <= sync_q;
      readdata <= rd_next;
      if (!capture_en) arm_cnt <= arm_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_amax10_qsys_bidir_pio.sv
// Directed bench for the bidirectional PIO: four instances cover rising, falling
// and any-edge capture plus non-zero reset values and reset during a write.
module tb_amax10_qsys_bidir_pio;

  logic        clk;
  logic        rst_n, rst_r_n;
  logic [2:0]  address;
  logic [3:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  tb_en0, tb_val0, tb_val12;
  logic [31:0] rd0, rd1, rd2, rd_r;
  logic        irq0, irq1, irq2, irq_r;
  wire  [7:0]  pins0, pins1, pins2, pins_r;

  logic [31:0] exp_q[$];
  int          n_checks, n_pass;

  localparam logic [3:0] SEL0 = 4'b0001, SEL1 = 4'b0010, SEL2 = 4'b0100, SELR = 4'b1000;

  for (genvar i = 0; i < 8; i++) begin : g_tb_pin
    assign pins0[i] = tb_en0[i] ? tb_val0[i] : 1'bz;
    assign pins1[i] = tb_val12[i];
    assign pins2[i] = tb_val12[i];
  end

  amax10_qsys_bidir_pio #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .irq(irq0), .bidir_port(pins0));

  amax10_qsys_bidir_pio #(.WIDTH(8), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .irq(irq1), .bidir_port(pins1));

  amax10_qsys_bidir_pio #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .irq(irq2), .bidir_port(pins2));

  amax10_qsys_bidir_pio #(.WIDTH(8), .RESET_OUT(8'h3C), .RESET_DIR(8'h0F)) dut_r (
    .clk(clk), .reset_n(rst_r_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r), .irq(irq_r), .bidir_port(pins_r));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drivers: called at a negedge, return at the next negedge.
  task automatic bus_write(input logic [3:0] sel, input logic [2:0] a, input logic [31:0] d);
    cs = sel; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    cs = '0; write_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input int dut, input logic [2:0] a,
                          input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    address = a;
    @(negedge clk);
    case (dut)
      0: got = rd0;
      1: got = rd1;
      2: got = rd2;
      default: got = rd_r;
    endcase
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; rst_r_n = 1'b0;
    address = '0; cs = '0; write_n = 1'b1; writedata = '0;
    tb_en0 = '0; tb_val0 = '0; tb_val12 = '0;
    repeat (2) @(negedge clk);
    check("rst_rd0", rd0, 32'h0);
    check("rst_irq0", 32'(irq0), 32'h0);
    check("rst_rd_r", rd_r, 32'h0);
    check("rst_pins_r", 32'(pins_r[3:0]), 32'hC);
    rst_n = 1'b1; rst_r_n = 1'b1;
    repeat (6) @(negedge clk);
    bus_read("ec_r_after_release", 3, 3'd3, 32'h0);
    bus_read("dir_r_reset", 3, 3'd1, 32'h0F);
    bus_read("mask_r_reset", 3, 3'd2, 32'h0);

    // Drive outputs and read them back through the synchroniser
    bus_write(SEL0, 3'd1, 32'hFF);
    bus_write(SEL0, 3'd0, 32'hA5);
    check("pins_a5", 32'(pins0), 32'hA5);
    repeat (2) @(negedge clk);
    bus_read("data_a5", 0, 3'd0, 32'h0000_00A5);
    bus_read("ec_driven_rise", 0, 3'd3, 32'hA5);
    bus_write(SEL0, 3'd3, 32'hFF);
    bus_read("ec_cleared", 0, 3'd3, 32'h0);

    // Set/clear access and write-only offsets
    bus_write(SEL0, 3'd0, 32'hF0);
    bus_write(SEL0, 3'd4, 32'h0F);
    check("pins_outset", 32'(pins0), 32'hFF);
    bus_write(SEL0, 3'd5, 32'h81);
    check("pins_outclr", 32'(pins0), 32'h7E);
    bus_read("rd_off4", 0, 3'd4, 32'h0);
    bus_read("rd_off5", 0, 3'd5, 32'h0);
    bus_read("rd_off6", 0, 3'd6, 32'h0);
    repeat (2) @(negedge clk);
    bus_read("data_7e", 0, 3'd0, 32'h7E);
    bus_read("ec_rises_only", 0, 3'd3, 32'h5F);
    bus_write(SEL0, 3'd3, 32'hFF);

    // Input mode: rising edge on pin 3, capture latency and masked irq
    bus_write(SEL0, 3'd1, 32'h00);
    tb_en0 = 8'hFF; tb_val0 = 8'h00;
    repeat (4) @(negedge clk);
    bus_write(SEL0, 3'd3, 32'hFF);
    bus_read("ec_pre_edge", 0, 3'd3, 32'h0);
    address = 3'd3; tb_val0 = 8'h08;
    repeat (3) @(posedge clk);
    #1 check("ec_not_yet", rd0, 32'h0);
    @(posedge clk);
    #1 check("ec_latency", rd0, 32'h08);
    check("irq_masked", 32'(irq0), 32'h0);
    @(negedge clk);
    bus_write(SEL0, 3'd2, 32'h08);
    check("irq_same_cycle", 32'(irq0), 32'h1);

    // New edge detected in the clearing cycle keeps its bit
    tb_val0 = 8'h00;
    repeat (4) @(negedge clk);
    bus_read("ec_hold_fall", 0, 3'd3, 32'h08);
    tb_val0 = 8'h08;
    repeat (2) @(negedge clk);
    bus_write(SEL0, 3'd3, 32'h08);
    bus_read("ec_set_wins", 0, 3'd3, 32'h08);
    bus_write(SEL0, 3'd3, 32'h08);
    bus_read("ec_w1c", 0, 3'd3, 32'h0);
    check("irq_cleared", 32'(irq0), 32'h0);

    // Any-edge versus falling-edge instances
    tb_val12 = 8'h01;
    repeat (5) @(negedge clk);
    bus_read("ec_any_rise", 2, 3'd3, 32'h01);
    bus_read("ec_fall_ignores_rise", 1, 3'd3, 32'h0);
    bus_write(SEL2, 3'd3, 32'h01);
    bus_read("ec_any_clr", 2, 3'd3, 32'h0);
    tb_val12 = 8'h00;
    repeat (5) @(negedge clk);
    bus_read("ec_any_fall", 2, 3'd3, 32'h01);
    bus_read("ec_fall", 1, 3'd3, 32'h01);

    // Reset asserted in the middle of a write
    bus_write(SELR, 3'd1, 32'hFF);
    bus_write(SELR, 3'd0, 32'hAA);
    bus_write(SELR, 3'd2, 32'hFF);
    repeat (4) @(negedge clk);
    check("pins_r_aa", 32'(pins_r), 32'hAA);
    check("irq_r_pre", 32'(irq_r), 32'h1);
    cs = SELR; write_n = 1'b0; address = 3'd0; writedata = 32'h55;
    #2 rst_r_n = 1'b0;
    #1;
    check("irq_r_in_reset", 32'(irq_r), 32'h0);
    check("pins_r_in_reset", 32'(pins_r[3:0]), 32'hC);
    check("rd_r_in_reset", rd_r, 32'h0);
    @(negedge clk);
    cs = '0; write_n = 1'b1;
    rst_r_n = 1'b1;
    repeat (5) @(negedge clk);
    bus_read("dir_r_after", 3, 3'd1, 32'h0F);
    bus_read("ec_r_after", 3, 3'd3, 32'h0);
    bus_read("mask_r_after", 3, 3'd2, 32'h0);
    check("irq_r_after", 32'(irq_r), 32'h0);
    bus_write(SELR, 3'd1, 32'hFF);
    check("out_r_after", 32'(pins_r), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/amax10_qsys_bidir_pio.md
AMAX10_QSYS_BIDIR_PIO -- requirements
Module: amax10_qsys_bidir_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of bidirectional pins, legal range 1..32.
REQ-002 SHALL have parameter RESET_OUT, default 0, reset value of the output-data register (WIDTH bits).
REQ-003 SHALL have parameter RESET_DIR, default 0, reset value of the direction register (1 = drive).
REQ-004 SHALL have parameter EDGE_TYPE, default 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-006 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port address, input, 3, register word offset.
REQ-009 SHALL have port chipselect, input, 1, Avalon slave select.
REQ-010 SHALL have port write_n, input, 1, active-low write strobe.
REQ-011 SHALL have port writedata, input, 32, write data; bits above WIDTH ignored.
REQ-012 SHALL have port readdata, output, 32, registered read data; bits above WIDTH read 0.
REQ-013 SHALL have port irq, output, 1, level interrupt.
REQ-014 SHALL have port bidir_port, inout, WIDTH, pins.

Function
REQ-015 SHALL use this register map: 0 data (R = synchronised pins, W = out register); 1 direction (R/W); 2 irqmask (R/W); 3 edgecapture (R, W1C); 4 outset (W only, ORs writedata into out register); 5 outclear (W only, clears out-register bits where writedata = 1); 6-7 reserved.
REQ-016 SHALL treat a write as chipselect = 1 and write_n = 0 in one cycle; register updates on that clock edge.
REQ-017 SHALL update readdata every clock from the current address, regardless of chipselect: read latency exactly 1 cycle.
REQ-018 SHALL return 0 for reads of offsets 4-7.
REQ-019 SHALL drive bidir_port[i] = out[i] when dir[i] = 1, else high-impedance, per bit, combinationally from the registers.
REQ-020 SHALL pass every pin through a SYNC_STAGES-deep flip-flop chain before any use; data reads and edge detection use only the synchronised value.
REQ-021 SHALL hold one extra delayed copy of the synchronised input and detect the selected edge per bit by comparing it with the synchronised value.
REQ-022 SHALL set edgecapture[i] on the cycle after a detected edge, independent of dir[i]; driven output transitions are therefore captured too.
REQ-023 SHALL clear edgecapture[i] on a write to offset 3 with writedata[i] = 1; an edge detected in the same cycle as the clear SHALL win (bit stays 1).
REQ-024 SHALL drive irq = OR over i of (edgecapture[i] AND irqmask[i]), combinational from registers, with no extra latency.
REQ-025 SHALL make a pin edge visible in edgecapture SYNC_STAGES+1 cycles after it lands at the pin, and in readdata offset 0 SYNC_STAGES+1 cycles after it lands.

Reset
REQ-026 SHALL, while reset_n = 0, asynchronously set out = RESET_OUT, dir = RESET_DIR, irqmask = 0, edgecapture = 0, readdata = 0, and all synchroniser and delay flops = 0.
REQ-027 SHALL suppress edge capture in the first SYNC_STAGES+1 cycles after reset release so that reset-value artefacts set no capture bits.
REQ-028 SHALL abandon any write in progress when reset asserts mid-cycle; no register retains partial state.

Structure
REQ-029 SHALL take register offsets (0-5) and EDGE_TYPE encodings from shared package amax10_qsys_pio_pkg.
REQ-030 SHALL implement the synchroniser as sub-module amax10_qsys_pio_sync (parameters WIDTH and SYNC_STAGES, async reset to 0), instantiated once.

Verification
REQ-031 SHALL cover: WIDTH=8; write dir=0xFF, data=0xA5 -> bidir_port=0xA5; read offset 0 one cycle later returns 0x000000A5 once synchronised.
REQ-032 SHALL cover: data=0xF0, outset 0x0F -> out=0xFF; then outclear 0x81 -> out=0x7E; reads of offsets 4/5 return 0.
REQ-033 SHALL cover: dir=0, EDGE_TYPE=0, pin 3 driven 0->1 -> edgecapture=0x08 after SYNC_STAGES+1 cycles; irq=0 with mask 0; write irqmask=0x08 -> irq=1 the same cycle the register updates.
REQ-034 SHALL cover: edgecapture=0x08, W1C 0x08 in the same cycle as a new rising edge on pin 3 is detected -> bit stays 1; W1C 0x08 alone -> 0, irq=0.
REQ-035 SHALL cover: EDGE_TYPE=2, pin 0 pulse 0->1->0 -> edgecapture[0]=1; EDGE_TYPE=1, rising edge only -> edgecapture stays 0.
REQ-036 SHALL cover: reset_n asserted mid-write with RESET_OUT=0x3C, RESET_DIR=0x0F -> out=0x3C, dir=0x0F, bidir_port=zzzz1100, edgecapture=0, irq=0 immediately, and no capture bits set after release.
